// File: rtl/uart_pkg.sv
// Shared UART constants and transmitter state encoding.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit after the data bits).
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;
`else
  localparam int unsigned FRAME_BITS = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd4
  } tx_state_e;
`endif

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with registered fill count and full/empty flags.
// Read data is the current head entry, valid whenever empty is low.
module uart_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data_c,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             full_q;
  logic             empty_q;
  logic             push;
  logic             pop;

  assign push      = wr_en & ~full_q;
  assign pop       = rd_en & ~empty_q;
  assign rd_data_c = mem[rd_ptr_q];
  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;

  // Next fill level; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage array; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // Pointers, count and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == CW'(0));
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter (8N1, or 8E1 with UART_TX_PARITY_EN defined) fed by a byte FIFO.
// All outputs are registered and trail the FSM by one cycle, so o_Tx_Active,
// o_Tx_Serial and o_Tx_Done line up with each other on the wire.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          serial_q, serial_c;
  logic          active_q, active_c;
  logic          done_q, done_c;
  logic          ready_q, ready_c;
  logic          pop_c;
  logic          push;
  logic          bit_end;
  logic [7:0]    fifo_rd_data;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] fill_c;
  logic          fifo_full;
  logic          fifo_empty;

  assign push    = i_Tx_DV & ~fifo_full;
  assign bit_end = (timer_q == TW'(CLKS_PER_BIT - 1));

  assign o_Tx_Ready  = ready_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Serial = serial_q;
  assign o_Tx_Done   = done_q;

  // Byte queue between the host strobe and the serializer.
  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (i_Clock),
    .rst_n     (i_Rst_n),
    .wr_en     (push),
    .wr_data   (i_Tx_Byte),
    .rd_en     (pop_c),
    .rd_data_c (fifo_rd_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Ready reflects the fill level after this edge, so a pop never lets a full FIFO accept.
  always_comb begin
    fill_c  = fifo_count + CW'(push) - CW'(pop_c);
    ready_c = (fill_c != CW'(FIFO_DEPTH));
  end

  // Next state, bit timing and line value for the current FSM state.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    pop_c    = 1'b0;
    serial_c = 1'b1;
    active_c = 1'b1;
    done_c   = 1'b0;

    if (state_q != ST_IDLE) begin
      timer_d = bit_end ? '0 : timer_q + TW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        active_c = 1'b0;
        timer_d  = '0;
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          shift_d = fifo_rd_data;
          state_d = ST_START;
        end
      end
      ST_START: begin
        serial_c = 1'b0;
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        serial_c = shift_q[0];
        if (bit_end) begin
          // Rotate so the original byte is restored after the eighth bit.
          shift_d = {shift_q[0], shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        serial_c = ^shift_q;
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          done_c = 1'b1;
          if (!fifo_empty) begin
            pop_c   = 1'b1;
            shift_d = fifo_rd_data;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, datapath and output registers.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      serial_q <= serial_c;
      active_q <= active_c;
      done_q   <= done_c;
      ready_q  <= ready_c;
    end
  end

endmodule
